// File: rtl/reg_file_2w2r.sv
// Two-write / two-read register file with optional hardwired-zero entry and a
// counter-driven clear sweep; define RF_BYPASS_EN for same-cycle write-to-read forwarding.
module reg_file_2w2r #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              clr,
  input  logic              wea,
  input  logic [ADDR_W-1:0] waddra,
  input  logic [DATA_W-1:0] dina,
  input  logic              web,
  input  logic [ADDR_W-1:0] waddrb,
  input  logic [DATA_W-1:0] dinb,
  input  logic [ADDR_W-1:0] raddra,
  input  logic [ADDR_W-1:0] raddrb,
  output logic [DATA_W-1:0] douta,
  output logic [DATA_W-1:0] doutb,
  output logic              busy
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam bit ZERO_EN = (ZERO_REG != 0);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              in_clear;
  logic              wr_en_a, wr_en_b;
  logic [DATA_W-1:0] entry_rd [DEPTH];

  assign in_clear = (state_q == CLEAR);
  assign busy     = in_clear;

  // Effective write strobes: dropped during a sweep, on a clear request, and
  // for entry 0 when it is hardwired to zero.
  assign wr_en_a = wea && !in_clear && !clr && !(ZERO_EN && (waddra == '0));
  assign wr_en_b = web && !in_clear && !clr && !(ZERO_EN && (waddrb == '0));

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (clr) begin
      state_d   = CLEAR;
      clr_cnt_d = '0;
    end else if (in_clear) begin
      if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
        state_d   = IDLE;
        clr_cnt_d = '0;
      end else begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // One register per entry; port B is checked first so it wins an address tie.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [DATA_W-1:0] entry_q;

      always_ff @(posedge clka) begin
        if (in_clear && (clr_cnt_q == ADDR_W'(gi))) begin
          entry_q <= '0;
        end else if (wr_en_b && (waddrb == ADDR_W'(gi))) begin
          entry_q <= dinb;
        end else if (wr_en_a && (waddra == ADDR_W'(gi))) begin
          entry_q <= dina;
        end
      end

      assign entry_rd[gi] = entry_q;
    end
  endgenerate

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] raddr);
    logic [DATA_W-1:0] rdata;
    rdata = entry_rd[raddr];
`ifdef RF_BYPASS_EN
    // Strobes already exclude clear and the zero entry, so forwarding inherits that.
    if (wr_en_a && (waddra == raddr)) rdata = dina;
    if (wr_en_b && (waddrb == raddr)) rdata = dinb;
`endif
    if (in_clear || (ZERO_EN && (raddr == '0))) rdata = '0;
    return rdata;
  endfunction

  assign douta = read_port(raddra);
  assign doutb = read_port(raddrb);

endmodule

// File: tb/tb_reg_file_2w2r.sv
// Directed bench for reg_file_2w2r: reset sweep, writes, port conflicts, clear,
// mid-sweep reset and read-during-write (expectation follows RF_BYPASS_EN).
module tb_reg_file_2w2r;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic              clka = 1'b0;
  logic              rsta = 1'b0;
  logic              clr = 1'b0;
  logic              wea = 1'b0;
  logic [ADDR_W-1:0] waddra = '0;
  logic [DATA_W-1:0] dina = '0;
  logic              web = 1'b0;
  logic [ADDR_W-1:0] waddrb = '0;
  logic [DATA_W-1:0] dinb = '0;
  logic [ADDR_W-1:0] raddra = '0;
  logic [ADDR_W-1:0] raddrb = '0;
  logic [DATA_W-1:0] douta;
  logic [DATA_W-1:0] doutb;
  logic              busy;

  int checks = 0;
  int errors = 0;

  reg_file_2w2r #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(1)
  ) dut (
    .clka  (clka),
    .rsta  (rsta),
    .clr   (clr),
    .wea   (wea),
    .waddra(waddra),
    .dina  (dina),
    .web   (web),
    .waddrb(waddrb),
    .dinb  (dinb),
    .raddra(raddra),
    .raddrb(raddrb),
    .douta (douta),
    .doutb (doutb),
    .busy  (busy)
  );

  always #5 clka = ~clka;

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic check(input string tag, input logic [DATA_W-1:0] observed,
                       input logic [DATA_W-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [DATA_W-1:0] rdw_exp;

    // Reset held for two edges: busy and reads forced
    #2 rsta = 1'b1;
    raddra = 5'd5;
    raddrb = 5'd31;
    tick();
    tick();
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_douta", douta, 32'd0);
    check("rst_doutb", doutb, 32'd0);
    $display("reset asserted: busy=%0d douta=%h doutb=%h", busy, douta, doutb);

    // Release: busy for exactly DEPTH edges
    rsta = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      check("sweep_busy", {31'd0, busy}, 32'd1);
      check("sweep_douta", douta, 32'd0);
      check("sweep_doutb", doutb, 32'd0);
      tick();
    end
    check("sweep_done", {31'd0, busy}, 32'd0);
    $display("reset sweep: busy=%0d after %0d edges", busy, DEPTH);

    // Single write, port A; read-during-write before the edge
    wea = 1'b1; waddra = 5'd3; dina = 32'hDEADBEEF; raddra = 5'd3;
    #1;
`ifdef RF_BYPASS_EN
    check("wr3_pre", douta, 32'hDEADBEEF);
`else
    check("wr3_pre", douta, 32'd0);
`endif
    tick();
    wea = 1'b0;
    #1;
    check("wr3_post", douta, 32'hDEADBEEF);
    $display("write a[3]=DEADBEEF: douta=%h", douta);

    // Hardwired zero entry
    wea = 1'b1; waddra = 5'd0; dina = 32'h1234;
    web = 1'b1; waddrb = 5'd0; dinb = 32'h5678;
    raddra = 5'd0; raddrb = 5'd0;
    tick();
    wea = 1'b0; web = 1'b0;
    #1;
    check("zero_a", douta, 32'd0);
    check("zero_b", doutb, 32'd0);
    $display("write to entry 0: douta=%h doutb=%h", douta, doutb);

    // Same-address conflict: B wins
    wea = 1'b1; waddra = 5'd7; dina = 32'h1111_1111;
    web = 1'b1; waddrb = 5'd7; dinb = 32'h2222_2222;
    tick();
    wea = 1'b0; web = 1'b0; raddra = 5'd7; raddrb = 5'd7;
    #1;
    check("conflict_a", douta, 32'h2222_2222);
    check("conflict_b", doutb, 32'h2222_2222);
    $display("conflict on 7: douta=%h doutb=%h", douta, doutb);

    // Different addresses, same edge
    wea = 1'b1; waddra = 5'd8; dina = 32'h0000_0088;
    web = 1'b1; waddrb = 5'd9; dinb = 32'h0000_0099;
    tick();
    wea = 1'b0; web = 1'b0; raddra = 5'd8; raddrb = 5'd9;
    #1;
    check("dual_a8", douta, 32'h0000_0088);
    check("dual_b9", doutb, 32'h0000_0099);
    $display("dual write 8/9: douta=%h doutb=%h", douta, doutb);

    // Fill 1..31 with index values
    for (int i = 1; i < DEPTH; i++) begin
      wea = 1'b1; waddra = ADDR_W'(i); dina = DATA_W'(i);
      tick();
    end
    wea = 1'b0; raddra = 5'd4; raddrb = 5'd31;
    #1;
    check("fill_4", douta, 32'd4);
    check("fill_31", doutb, 32'd31);
    $display("fill: a[4]=%h a[31]=%h", douta, doutb);

    // Clear request with a write on the same edge
    clr = 1'b1; wea = 1'b1; waddra = 5'd4; dina = 32'hFF;
    tick();
    clr = 1'b0; wea = 1'b0;
    #1;
    check("clr_rd31_masked", doutb, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      check("clr_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    check("clr_done", {31'd0, busy}, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      raddra = ADDR_W'(i); raddrb = ADDR_W'(DEPTH - 1 - i);
      #1;
      check("clr_zero_a", douta, 32'd0);
      check("clr_zero_b", doutb, 32'd0);
    end
    $display("clear sweep done: busy=%0d all entries zero", busy);

    // Reset at sweep cycle 10, then a write attempted at sweep cycle 20
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rsta = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd1);
    tick();
    rsta = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      check("midrst_sweep", {31'd0, busy}, 32'd1);
      if (i == 20) begin
        wea = 1'b1; waddra = 5'd12; dina = 32'h55;
      end
      tick();
      wea = 1'b0;
    end
    raddra = 5'd12;
    #1;
    check("midrst_done", {31'd0, busy}, 32'd0);
    check("midrst_wr_drop", douta, 32'd0);
    $display("mid-sweep reset: busy=%0d a[12]=%h", busy, douta);

    // Read-during-write on port B, old value 1
    wea = 1'b1; waddra = 5'd6; dina = 32'h1;
    tick();
    wea = 1'b1; waddra = 5'd6; dina = 32'hCAFE; raddrb = 5'd6; raddra = 5'd6;
    #1;
`ifdef RF_BYPASS_EN
    rdw_exp = 32'hCAFE;
`else
    rdw_exp = 32'h1;
`endif
    check("rdw_b_pre", doutb, rdw_exp);
    check("rdw_a_pre", douta, rdw_exp);
    tick();
    wea = 1'b0;
    #1;
    check("rdw_a_post", douta, 32'hCAFE);
    check("rdw_b_post", doutb, 32'hCAFE);
    $display("read-during-write 6: doutb=%h", doutb);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_2w2r.md
Name: reg_file_2w2r

Overview:
Parametrised multi-port register file for the R/I/J CPU datapath and successor cores. It has two asynchronous read ports and two synchronous write ports with a defined write-conflict priority. An optional hardwired-zero register is supported. Clearing is a counter-driven sweep, one entry per cycle, triggered by reset or a synchronous clear request, with a busy indication.

Parameters:
DATA_W, 32, data width of each entry in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes; 0 = entry 0 is an ordinary register

Ports:
clka  input  1  clock, rising edge
rsta  input  1  reset, asynchronous, active-high
clr  input  1  synchronous clear request, sampled on clka rising edge
wea  input  1  write enable, port A
waddra  input  ADDR_W  write address, port A
dina  input  DATA_W  write data, port A
web  input  1  write enable, port B
waddrb  input  ADDR_W  write address, port B
dinb  input  DATA_W  write data, port B
raddra  input  ADDR_W  read address, port A
raddrb  input  ADDR_W  read address, port B
douta  output  DATA_W  read data, port A
doutb  output  DATA_W  read data, port B
busy  output  1  clear sweep in progress

Behaviour:
- Reset: clka, rsta; rsta asynchronous, active-high.
- State machine: two states, IDLE and CLEAR, plus a clear counter clr_cnt of width ADDR_W.
- While rsta is high:
  - state = CLEAR, clr_cnt = 0.
  - busy = 1, douta = doutb = 0.
  - Array contents are not touched asynchronously.
- CLEAR state, each clka edge:
  - entry[clr_cnt] <= 0, then clr_cnt increments.
  - On the edge where clr_cnt == DEPTH-1: that entry is cleared, state -> IDLE.
  - Sweep length = DEPTH cycles after the rsta deassertion edge; busy falls after the DEPTH-th edge.
- During CLEAR:
  - douta = doutb = 0 regardless of address.
  - wea and web are ignored; writes are dropped, not queued.
- clr = 1 in IDLE: state -> CLEAR, clr_cnt = 0. Any write presented on the same edge is dropped.
- clr = 1 in CLEAR: clr_cnt restarts at 0, so the sweep is extended.
- rsta asserted mid-sweep: asynchronous restart at clr_cnt = 0.
- IDLE writes, on the clka rising edge:
  - wea: entry[waddra] <= dina.
  - web: entry[waddrb] <= dinb.
  - Both enabled with waddra == waddrb: port B wins, port A is discarded.
  - Both enabled with different addresses: both writes occur on the same edge.
- ZERO_REG = 1:
  - Writes to address 0 from either port are dropped.
  - Reads of address 0 return 0.
  - Entry 0 is still swept by CLEAR.
- IDLE reads: combinational, zero latency.
  - douta = entry[raddra], doutb = entry[raddrb].
  - Both ports may read the same address.
- Read-during-write to the same address (feature off): the read returns the old value; the new value is visible after the edge.
- busy is registered state decode: busy = (state == CLEAR).

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - In IDLE, when a read address matches an enabled write address in the same cycle, the read port returns the incoming write data combinationally.
  - If both write ports match, dinb has priority.
  - No bypass applies to address 0 when ZERO_REG = 1, and no bypass applies during CLEAR.
- Undefined: reads return stored contents only, i.e. old data during a same-cycle write.

Test Plan:
- Pulse rsta, release, hold all else 0 -> busy = 1 for exactly 32 edges then 0; reads of raddra = 5 and raddrb = 31 return 0 throughout.
- IDLE: wea = 1, waddra = 3, dina = 0xDEADBEEF -> after the edge, raddra = 3 gives douta = 0xDEADBEEF. Write waddra = 0, dina = 0x1234 (ZERO_REG = 1) -> douta at raddra = 0 stays 0.
- wea = web = 1, waddra = waddrb = 7, dina = 0x1111_1111, dinb = 0x2222_2222 -> entry 7 reads 0x2222_2222. Then waddra = 8, waddrb = 9 -> both entries written on the same edge.
- Fill entries 1..31 with their index values, then pulse clr for 1 cycle with wea = 1, waddra = 4, dina = 0xFF -> busy high for 32 edges; the write is dropped; afterwards all entries read 0.
- Assert rsta at sweep cycle 10, release -> busy lasts a full 32 further edges. A write attempted at sweep cycle 20 is ignored.
- Bypass: wea = 1, waddra = 6, dina = 0xCAFE, raddrb = 6 in the same cycle, old value 0x1 -> doutb = 0xCAFE with RF_BYPASS_EN defined, 0x1 without; after the edge both give 0xCAFE.
